// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM states,
// instruction field encodings and the ALU operation codes also used by the ALU.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    // Opcode field, instruction bits [31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Funct field, instruction bits [5:0], R-type only
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_MULT = 6'b011000;

    // ALU_Control codes understood by the 32-bit ALU
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

    // ALU_Op selector from the FSM to the ALU control decoder
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // True for every opcode the controller knows how to sequence
    function automatic logic is_supported_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/alu_control_decoder.sv
// Maps the FSM's ALU_Op request and the instruction Funct field onto an
// ALU_Control code. Unknown Funct values fall back to ADD without flagging.
module alu_control_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] alu_op,
    output logic [2:0] alu_control
);

    // Pure decode: fixed ADD/SUB for address and branch math, Funct otherwise
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_ADD;
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct)
                    FUNCT_ADD:  alu_control = ALU_ADD;
                    FUNCT_SUB:  alu_control = ALU_SUB;
                    FUNCT_AND:  alu_control = ALU_AND;
                    FUNCT_OR:   alu_control = ALU_OR;
                    FUNCT_SLT:  alu_control = ALU_SLT;
                    FUNCT_MULT: alu_control = ALU_MUL;
                    default:    alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM. Moore outputs decoded from the state register;
// PC_En alone mixes in Zero_Flag so beq resolves in the BRANCH cycle.
// While RST is high every output is held at 0.
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero_Flag,
    output logic       IorD,
    output logic       Mem_Write,
    output logic       IR_Write,
    output logic       Reg_Write,
    output logic       Reg_Dst,
    output logic       Mem_To_Reg,
    output logic       ALU_Src_A,
    output logic [1:0] ALU_Src_B,
    output logic [2:0] ALU_Control,
    output logic [1:0] PC_Src,
    output logic       PC_En,
    output logic       Illegal_Op
);

    // Current state is kept under a plain name so checkers can bind to it
    state_t     state;
    state_t     next_state;

    logic       pc_write;
    logic       branch;
    logic [1:0] alu_op;
    logic       alu_active;
    logic [2:0] decoded_alu_control;

    alu_control_decoder u_alu_control_decoder (
        .funct       (Funct),
        .alu_op      (alu_op),
        .alu_control (decoded_alu_control)
    );

    // State register; reset drops any in-flight instruction back to FETCH
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; Opcode is stable from DECODE onward
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR:  next_state = (Opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   next_state = MEMWB;
            MEMWB:   next_state = FETCH;
            MEMWR:   next_state = FETCH;
            EXECUTE: next_state = ALUWB;
            ALUWB:   next_state = FETCH;
            ADDIEX:  next_state = ADDIWB;
            ADDIWB:  next_state = FETCH;
            BRANCH:  next_state = FETCH;
            JUMP:    next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    // Output decode; every signal not set for a state stays 0
    always_comb begin
        IorD       = 1'b0;
        Mem_Write  = 1'b0;
        IR_Write   = 1'b0;
        Reg_Write  = 1'b0;
        Reg_Dst    = 1'b0;
        Mem_To_Reg = 1'b0;
        ALU_Src_A  = 1'b0;
        ALU_Src_B  = 2'b00;
        PC_Src     = 2'b00;
        Illegal_Op = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        alu_op     = ALU_OP_ADD;
        alu_active = 1'b0;
        case (state)
            FETCH: begin
                ALU_Src_B  = 2'b01;
                alu_active = 1'b1;
                IR_Write   = 1'b1;
                pc_write   = 1'b1;
            end
            DECODE: begin
                // Branch target computed here so BRANCH can load it from ALUOut
                ALU_Src_B  = 2'b11;
                alu_active = 1'b1;
                Illegal_Op = !is_supported_op(Opcode);
            end
            MEMADR, ADDIEX: begin
                ALU_Src_A  = 1'b1;
                ALU_Src_B  = 2'b10;
                alu_active = 1'b1;
            end
            MEMRD: IorD = 1'b1;
            MEMWR: begin
                IorD      = 1'b1;
                Mem_Write = 1'b1;
            end
            MEMWB: begin
                Mem_To_Reg = 1'b1;
                Reg_Write  = 1'b1;
            end
            EXECUTE: begin
                ALU_Src_A  = 1'b1;
                alu_op     = ALU_OP_FUNCT;
                alu_active = 1'b1;
            end
            ALUWB: begin
                Reg_Dst   = 1'b1;
                Reg_Write = 1'b1;
            end
            ADDIWB: Reg_Write = 1'b1;
            BRANCH: begin
                ALU_Src_A  = 1'b1;
                alu_op     = ALU_OP_SUB;
                alu_active = 1'b1;
                PC_Src     = 2'b01;
                branch     = 1'b1;
            end
            JUMP: begin
                PC_Src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        if (RST) begin
            IorD       = 1'b0;
            Mem_Write  = 1'b0;
            IR_Write   = 1'b0;
            Reg_Write  = 1'b0;
            Reg_Dst    = 1'b0;
            Mem_To_Reg = 1'b0;
            ALU_Src_A  = 1'b0;
            ALU_Src_B  = 2'b00;
            PC_Src     = 2'b00;
            Illegal_Op = 1'b0;
            pc_write   = 1'b0;
            branch     = 1'b0;
            alu_active = 1'b0;
        end
    end

    // PC load and gated ALU code; states that do not use the ALU drive 000
    assign PC_En       = pc_write | (branch & Zero_Flag);
    assign ALU_Control = alu_active ? decoded_alu_control : 3'b000;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for the multicycle MIPS controller. Outputs are packed into
// one vector and compared cycle by cycle against hand-written state vectors.
module tb_mips_multicycle_controller;

    logic       CLK;
    logic       RST;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero_Flag;
    logic       IorD;
    logic       Mem_Write;
    logic       IR_Write;
    logic       Reg_Write;
    logic       Reg_Dst;
    logic       Mem_To_Reg;
    logic       ALU_Src_A;
    logic [1:0] ALU_Src_B;
    logic [2:0] ALU_Control;
    logic [1:0] PC_Src;
    logic       PC_En;
    logic       Illegal_Op;

    int checks = 0;
    int errors = 0;

    mips_multicycle_controller dut (
        .CLK         (CLK),
        .RST         (RST),
        .Opcode      (Opcode),
        .Funct       (Funct),
        .Zero_Flag   (Zero_Flag),
        .IorD        (IorD),
        .Mem_Write   (Mem_Write),
        .IR_Write    (IR_Write),
        .Reg_Write   (Reg_Write),
        .Reg_Dst     (Reg_Dst),
        .Mem_To_Reg  (Mem_To_Reg),
        .ALU_Src_A   (ALU_Src_A),
        .ALU_Src_B   (ALU_Src_B),
        .ALU_Control (ALU_Control),
        .PC_Src      (PC_Src),
        .PC_En       (PC_En),
        .Illegal_Op  (Illegal_Op)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Packed order: IorD MemW IRW RegW RegDst MemToReg SrcA SrcB[2] AluCtl[3] PCSrc[2] PCEn Illegal
    logic [15:0] outs;
    assign outs = {IorD, Mem_Write, IR_Write, Reg_Write, Reg_Dst, Mem_To_Reg, ALU_Src_A,
                   ALU_Src_B, ALU_Control, PC_Src, PC_En, Illegal_Op};

    localparam logic [15:0] V_ZERO     = 16'h0000;
    localparam logic [15:0] V_FETCH    = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,3'b010,2'b00,1'b1,1'b0};
    localparam logic [15:0] V_DECODE   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b010,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_DEC_ILL  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b010,2'b00,1'b0,1'b1};
    localparam logic [15:0] V_MEMADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b010,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_MEMRD    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_MEMWR    = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_MEMWB    = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_ALUWB    = {1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_ADDIWB   = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_BR_TAKEN = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b100,2'b01,1'b1,1'b0};
    localparam logic [15:0] V_BR_NOT   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b100,2'b01,1'b0,1'b0};
    localparam logic [15:0] V_JUMP     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b10,1'b1,1'b0};
    // EXECUTE vectors: SrcA=1, SrcB=00, ALU code from Funct
    localparam logic [15:0] V_EX_SUB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b100,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_EX_SLT   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b110,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_EX_MUL   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b101,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_EX_AND   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b000,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_EX_OR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b001,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_EX_ADD   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b010,2'b00,1'b0,1'b0};

    // Reset held for two edges with all outputs forced low, then FETCH appears
    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1;
        Opcode = 6'b100011;
        Funct = 6'b000000;
        Zero_Flag = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            #1;
            checks++;
            if (outs !== V_ZERO) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %b want %b", c, outs, V_ZERO);
            end
        end
        @(negedge CLK);
        RST = 1'b0;
        Zero_Flag = 1'b0;
        #1;
        checks++;
        if (outs !== V_FETCH) begin
            errors++;
            $display("FAIL reset_release: got %b want %b", outs, V_FETCH);
        end
    endtask

    // lw: five cycles, write-back only in the fifth, FETCH in the sixth
    task automatic test_lw();
        logic [15:0] exp [6];
        exp[0] = V_FETCH;  exp[1] = V_DECODE; exp[2] = V_MEMADR;
        exp[3] = V_MEMRD;  exp[4] = V_MEMWB;  exp[5] = V_FETCH;
        Opcode = 6'b100011;
        Funct = 6'b000000;
        Zero_Flag = 1'b0;
        #1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                @(negedge CLK);
                #1;
            end
            checks++;
            if (outs !== exp[c]) begin
                errors++;
                $display("FAIL lw cycle %0d: got %b want %b", c, outs, exp[c]);
            end
        end
    endtask

    // R-type with several Funct codes, including an unknown one that adds
    task automatic test_rtype();
        logic [5:0]  functs [7];
        logic [15:0] ex_v [7];
        logic [15:0] exp [5];
        functs[0] = 6'b100010; ex_v[0] = V_EX_SUB;
        functs[1] = 6'b101010; ex_v[1] = V_EX_SLT;
        functs[2] = 6'b011000; ex_v[2] = V_EX_MUL;
        functs[3] = 6'b100100; ex_v[3] = V_EX_AND;
        functs[4] = 6'b100101; ex_v[4] = V_EX_OR;
        functs[5] = 6'b100000; ex_v[5] = V_EX_ADD;
        functs[6] = 6'b111111; ex_v[6] = V_EX_ADD;
        for (int k = 0; k < 7; k++) begin
            exp[0] = V_FETCH; exp[1] = V_DECODE; exp[2] = ex_v[k];
            exp[3] = V_ALUWB; exp[4] = V_FETCH;
            Opcode = 6'b000000;
            Funct = functs[k];
            #1;
            for (int c = 0; c < 5; c++) begin
                if (c > 0) begin
                    @(negedge CLK);
                    #1;
                end
                checks++;
                if (outs !== exp[c]) begin
                    errors++;
                    $display("FAIL rtype funct %b cycle %0d: got %b want %b", functs[k], c, outs, exp[c]);
                end
            end
        end
    endtask

    // beq taken then not taken; PC_En follows Zero_Flag in BRANCH only
    task automatic test_beq();
        logic [15:0] exp [4];
        for (int k = 0; k < 2; k++) begin
            exp[0] = V_FETCH; exp[1] = V_DECODE;
            exp[2] = (k == 0) ? V_BR_TAKEN : V_BR_NOT;
            exp[3] = V_FETCH;
            Opcode = 6'b000100;
            Funct = 6'b000000;
            Zero_Flag = (k == 0);
            #1;
            for (int c = 0; c < 4; c++) begin
                if (c > 0) begin
                    @(negedge CLK);
                    #1;
                end
                checks++;
                if (outs !== exp[c]) begin
                    errors++;
                    $display("FAIL beq zero=%0d cycle %0d: got %b want %b", Zero_Flag, c, outs, exp[c]);
                end
            end
        end
        Zero_Flag = 1'b0;
    endtask

    // sw followed immediately by an unsupported opcode
    task automatic test_sw_illegal();
        logic [15:0] exp [7];
        exp[0] = V_FETCH;  exp[1] = V_DECODE; exp[2] = V_MEMADR;
        exp[3] = V_MEMWR;  exp[4] = V_FETCH;  exp[5] = V_DEC_ILL;
        exp[6] = V_FETCH;
        Opcode = 6'b101011;
        Funct = 6'b000000;
        #1;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) begin
                @(negedge CLK);
                if (c == 4) Opcode = 6'b111111;
                #1;
            end
            checks++;
            if (outs !== exp[c]) begin
                errors++;
                $display("FAIL sw_illegal cycle %0d: got %b want %b", c, outs, exp[c]);
            end
        end
    endtask

    // addi and j back to back
    task automatic test_addi_j();
        logic [15:0] exp [7];
        exp[0] = V_FETCH;  exp[1] = V_DECODE; exp[2] = V_MEMADR;
        exp[3] = V_ADDIWB; exp[4] = V_FETCH;  exp[5] = V_DECODE;
        exp[6] = V_JUMP;
        Opcode = 6'b001000;
        Funct = 6'b100010;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                @(negedge CLK);
                if (c == 4) Opcode = 6'b000010;
                #1;
            end
            checks++;
            if (outs !== ((c == 7) ? V_FETCH : exp[c])) begin
                errors++;
                $display("FAIL addi_j cycle %0d: got %b want %b", c, outs, (c == 7) ? V_FETCH : exp[c]);
            end
        end
    endtask

    // Reset lands in the MEMWR cycle of a sw: no write, FETCH after release
    task automatic test_reset_mid();
        logic [15:0] exp [3];
        exp[0] = V_FETCH; exp[1] = V_DECODE; exp[2] = V_MEMADR;
        Opcode = 6'b101011;
        Funct = 6'b000000;
        #1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin
                @(negedge CLK);
                #1;
            end
            checks++;
            if (outs !== exp[c]) begin
                errors++;
                $display("FAIL reset_mid pre cycle %0d: got %b want %b", c, outs, exp[c]);
            end
        end
        @(negedge CLK);
        RST = 1'b1;
        #1;
        checks++;
        if (Mem_Write !== 1'b0 || outs !== V_ZERO) begin
            errors++;
            $display("FAIL reset_mid memwr: got %b want %b", outs, V_ZERO);
        end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        checks++;
        if (outs !== V_FETCH) begin
            errors++;
            $display("FAIL reset_mid release: got %b want %b", outs, V_FETCH);
        end
        @(negedge CLK);
        #1;
        checks++;
        if (outs !== V_DECODE) begin
            errors++;
            $display("FAIL reset_mid decode: got %b want %b", outs, V_DECODE);
        end
    endtask

    // Sequence of scenarios and final report
    initial begin
        RST = 1'b1;
        Opcode = 6'b000000;
        Funct = 6'b000000;
        Zero_Flag = 1'b0;
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_sw_illegal();
        test_addi_j();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mips_multicycle_controller.md
# mips_multicycle_controller

Multicycle MIPS control FSM that drives the datapath around the 32-bit ALU: it produces ALU_Control and operand selects, and consumes Zero_Flag for branch resolution. It sits between the instruction register (Opcode/Funct fields) and the shared-memory, register-file and PC enables. Supported instructions: R-type (add, sub, and, or, slt, mult), lw, sw, beq, addi, j.

## Interface
- No parameters.
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- Opcode  in  6  instruction bits [31:26] from the instruction register
- Funct  in  6  instruction bits [5:0]
- Zero_Flag  in  1  ALU zero flag, valid in the same cycle
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- Mem_Write  out  1  memory write enable
- IR_Write  out  1  instruction register load
- Reg_Write  out  1  register-file write enable
- Reg_Dst  out  1  destination register: 0 = rt, 1 = rd
- Mem_To_Reg  out  1  write-back source: 0 = ALUOut, 1 = memory data
- ALU_Src_A  out  1  0 = PC, 1 = register A
- ALU_Src_B  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALU_Control  out  3  000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL, 110 SLT
- PC_Src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- PC_En  out  1  PC load: PC_Write | (Branch & Zero_Flag)
- Illegal_Op  out  1  single-cycle pulse on an unsupported opcode

## Operation
- Opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Transitions:
  - FETCH→DECODE
  - DECODE→MEMADR (lw/sw), EXECUTE (R), BRANCH (beq), ADDIEX (addi), JUMP (j), or FETCH (any other opcode)
  - MEMADR→MEMRD (lw) or MEMWR (sw)
  - MEMRD→MEMWB→FETCH
  - MEMWR→FETCH
  - EXECUTE→ALUWB→FETCH
  - ADDIEX→ADDIWB→FETCH
  - BRANCH→FETCH
  - JUMP→FETCH
- Outputs are Moore, decoded from the state register. The only exception is PC_En, which uses Zero_Flag combinationally. Any signal not listed for a state is 0.
  - FETCH: IorD=0, ALU_Src_A=0, ALU_Src_B=01, ALU_Control=010, PC_Src=00, IR_Write=1, PC_Write=1
  - DECODE: ALU_Src_A=0, ALU_Src_B=11, ALU_Control=010 (precomputes the branch target)
  - MEMADR and ADDIEX: ALU_Src_A=1, ALU_Src_B=10, ALU_Control=010
  - MEMRD: IorD=1
  - MEMWR: IorD=1, Mem_Write=1
  - MEMWB: Reg_Dst=0, Mem_To_Reg=1, Reg_Write=1
  - EXECUTE: ALU_Src_A=1, ALU_Src_B=00, ALU_Control=decoded Funct
  - ALUWB: Reg_Dst=1, Mem_To_Reg=0, Reg_Write=1
  - ADDIWB: Reg_Dst=0, Mem_To_Reg=0, Reg_Write=1
  - BRANCH: ALU_Src_A=1, ALU_Src_B=00, ALU_Control=100, PC_Src=01, Branch=1
  - JUMP: PC_Src=10, PC_Write=1
- Funct decode:
  - 100000→010
  - 100010→100
  - 100100→000
  - 100101→001
  - 101010→110
  - 011000→101
  - any other Funct→010. No illegal flag is raised for an unknown Funct.
- Illegal_Op is 1 only in DECODE when the opcode is unsupported. The FSM then returns to FETCH with no write enables asserted.
- Opcode and Funct are sampled every cycle and are assumed stable from DECODE onward, because IR_Write is asserted only in FETCH.

## Timing
- Reset: while RST=1 at a rising edge, the state becomes FETCH. While RST is high, all outputs are forced to 0, including PC_En, IR_Write, Mem_Write and Reg_Write.
- First cycle after RST deasserts: the FETCH outputs are active.
- Reset mid-instruction: the instruction is abandoned and no further write enable asserts.
- Cycles per instruction, counted from FETCH:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal opcode 2
- beq: PC_En in the BRANCH cycle equals Zero_Flag in that same cycle. It is taken if Zero_Flag=1; otherwise the PC keeps the PC+4 value already written in FETCH.
- Exactly one PC update per FETCH, plus at most one more in BRANCH or JUMP. Mem_Write and Reg_Write never assert in the same cycle.

## Structure
- Shared package mips_ctrl_pkg holds:
  - the state enum
  - the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - the Funct constants
  - the ALU_Control codes, which are shared with the ALU
- One combinational sub-module, alu_control_decoder, takes Funct and ALU_Op[1:0] and produces ALU_Control:
  - ALU_Op 00 = ADD
  - ALU_Op 01 = SUB
  - ALU_Op 10 = Funct decode
- The FSM contains the state register, the next-state logic and the output decode.

## Test plan
- RST high for 2 cycles, then low → all outputs 0 during reset; next cycle IR_Write=1, PC_Write=1, ALU_Src_B=01, ALU_Control=010.
- Opcode=100011 (lw) → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. Reg_Write=1 and Mem_To_Reg=1 only in cycle 5; back to FETCH in cycle 6.
- Opcode=000000 with Funct=100010, 101010 and 011000 → in EXECUTE, ALU_Control=100, 110 and 101 respectively. ALUWB has Reg_Dst=1, Reg_Write=1.
- Opcode=000100 with Zero_Flag=1, then a second beq with Zero_Flag=0 → in BRANCH, PC_En=1 and PC_Src=01 for the first; PC_En=0 for the second. Both take 3 cycles.
- Opcode=101011 (sw) followed by opcode=111111 → Mem_Write=1 only in cycle 4 of the sw. Illegal_Op=1 in DECODE of the second instruction, no write enables, FETCH follows.
- RST asserted during MEMWR → Mem_Write=0 in that cycle; FETCH outputs appear in the first cycle after RST deasserts.
